pinky_scoreboard_regfile: RTL and testbench
===========================================

// Module: pinky_scoreboard_regfile
// PURPOSE
//  Parametrised PinKY register file with per-register pending-write scoreboard and write-back bypass.
//  Sits between decode (read ports, issue) and write-back (write port) of the pipelined PinKY core.
//  Replaces hierarchical regfile access; decode stalls on rd_busy instead of reading stale values.
// PARAMETERS
//  WIDTH     16  data word width in bits
//  NREGS     16  number of registers; AW = $clog2(NREGS)
//  NRD       2   number of read ports (Rd and Op2 today)
//  MAXPEND   3   max outstanding writes per register; CW = $clog2(MAXPEND+1)
//  ZERO_R0   0   1: register 0 reads 0, writes to it are discarded, never pending
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous reset, active-low (asserted when 0)
//  rd_addr    in   NRD*AW     read addresses, port i at [i*AW +: AW]
//  rd_data    out  NRD*WIDTH  read data, combinational, port i at [i*WIDTH +: WIDTH]
//  rd_busy    out  NRD        port i register has an uncovered pending write
//  iss_valid  in   1          decode issues an instruction this cycle
//  iss_wen    in   1          issued instruction writes a register
//  iss_dest   in   AW         destination of issued instruction
//  iss_ready  out  1          issue accepted; 0 when iss_dest counter == MAXPEND
//  wb_valid   in   1          write-back this cycle
//  wb_dest    in   AW         write-back register
//  wb_data    in   WIDTH      write-back value
//  err        out  1          sticky: write-back to a register with pend count 0
// BEHAVIOUR
//  Reset (reset==0, async): all registers 0, all pend counters 0, err 0; rd_busy 0; iss_ready 1.
//  State per register r: regs[r] (WIDTH), pend[r] (CW, saturates at MAXPEND).
//  Issue fires when iss_valid & iss_wen & iss_ready; iss_ready = (pend[iss_dest] != MAXPEND).
//  Issue with iss_wen=0: no state change, iss_ready still reflects pend[iss_dest].
//  Write-back fires when wb_valid: regs[wb_dest] <= wb_data at next edge.
//  Counter update at edge: +1 on issue fire, -1 on wb to same reg; both same cycle -> unchanged.
//  Underflow: wb with pend[wb_dest]==0 and no same-cycle issue to it -> data written, pend stays 0, err<=1.
//  err clears only on reset.
//  Read, port i, a = rd_addr[i] (combinational, zero latency):
//   bypass = wb_valid & wb_dest==a & pend[a]==1
//   rd_data = bypass ? wb_data : regs[a]
//   rd_busy = (pend[a]!=0) & ~bypass
//  pend[a]>1 with matching wb: rd_data = regs[a] (older value), rd_busy=1 (younger write outstanding).
//  Same-cycle issue to a does not affect that cycle's reads (issue visible next cycle).
//  ZERO_R0=1: a==0 -> rd_data 0, rd_busy 0; issue/wb to 0 do not touch pend[0]; no err for r0.
//  All read ports independent; same address on several ports returns identical data/busy.
//  Reset mid-operation: state cleared immediately; wb arriving after release to pend 0 sets err.
//  Addresses >= NREGS (non-power-of-2 NREGS): reads return 0/not busy, issue/wb ignored.
// TESTING
//  1 Reset release, read r0..r15 on both ports -> rd_data 0, rd_busy 0, iss_ready 1, err 0.
//  2 Issue r3, next cycle read r3 -> rd_busy 1; wb r3=16'hBEEF same cycle -> rd_data BEEF, rd_busy 0;
//    following cycle read r3 -> BEEF, rd_busy 0.
//  3 Issue r5 x3 (MAXPEND=3) -> 4th issue iss_ready 0, pend stays 3; one wb r5 -> iss_ready 1,
//    read during that wb -> rd_busy 1, old data.
//  4 pend[r7]=1, same cycle issue r7 and wb r7=16'h0012 -> pend[r7] stays 1, regs[r7]=0012, rd_busy 1.
//  5 wb r9=16'h0001 with pend 0 -> regs[r9]=0001, err 1; err held through further traffic until reset.
//  6 Issue r2, pull reset low mid-cycle -> pend, regs, err cleared asynchronously; ZERO_R0=1 build:
//    wb r0=16'hFFFF -> read r0 returns 0, err 0.

Source files
------------

// File: rtl/pinky_scoreboard_regfile.sv
// PinKY register file with per-register pending-write counters and write-back bypass.
// Decode reads combinationally and stalls on rd_busy; write-back retires pending writes.
module pinky_scoreboard_regfile #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 16,
  parameter int NRD     = 2,
  parameter int MAXPEND = 3,
  parameter int ZERO_R0 = 0,
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int CW = $clog2(MAXPEND + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 iss_valid,
  input  logic                 iss_wen,
  input  logic [AW-1:0]        iss_dest,
  output logic                 iss_ready,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_dest,
  input  logic [WIDTH-1:0]     wb_data,
  output logic                 err
);

  logic [WIDTH-1:0] regs_r   [NREGS];
  logic [CW-1:0]    pend_r   [NREGS];
  logic [CW-1:0]    pend_nxt_s [NREGS];
  logic             err_r;
  logic             iss_fire_s;
  logic             wb_fire_s;
  logic             underflow_s;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return int'(a) < NREGS;
  endfunction

  // A register is tracked when it exists and is not the hardwired zero register.
  function automatic logic tracked(input logic [AW-1:0] a);
    return addr_ok(a) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  // Issue acceptance and write-back qualification.
  always_comb begin
    iss_ready = 1'b1;
    if (tracked(iss_dest) && (pend_r[iss_dest] == CW'(MAXPEND))) begin
      iss_ready = 1'b0;
    end else begin
      iss_ready = 1'b1;
    end
    iss_fire_s  = iss_valid && iss_wen && iss_ready && tracked(iss_dest);
    wb_fire_s   = wb_valid && tracked(wb_dest);
    underflow_s = 1'b0;
    if (wb_fire_s && (pend_r[wb_dest] == '0) && !(iss_fire_s && (iss_dest == wb_dest))) begin
      underflow_s = 1'b1;
    end else begin
      underflow_s = 1'b0;
    end
  end

  // Next pending count: issue and retire in the same cycle cancel out.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pend_nxt_s[i] = pend_r[i];
      if (iss_fire_s && (iss_dest == AW'(i)) && wb_fire_s && (wb_dest == AW'(i))) begin
        pend_nxt_s[i] = pend_r[i];
      end else if (iss_fire_s && (iss_dest == AW'(i))) begin
        pend_nxt_s[i] = pend_r[i] + CW'(1);
      end else if (wb_fire_s && (wb_dest == AW'(i)) && (pend_r[i] != '0)) begin
        pend_nxt_s[i] = pend_r[i] - CW'(1);
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
    end
  end

  // Register contents and pending counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
        pend_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        pend_r[i] <= pend_nxt_s[i];
      end
      if (wb_fire_s) begin
        regs_r[wb_dest] <= wb_data;
      end
    end
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (underflow_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;

  // Read ports: forward the write-back only when it retires the last pending write.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (tracked(rd_addr[p*AW +: AW])) begin
        if (wb_valid && (wb_dest == rd_addr[p*AW +: AW]) &&
            (pend_r[rd_addr[p*AW +: AW]] == CW'(1))) begin
          rd_data[p*WIDTH +: WIDTH] = wb_data;
          rd_busy[p]                = 1'b0;
        end else begin
          rd_data[p*WIDTH +: WIDTH] = regs_r[rd_addr[p*AW +: AW]];
          rd_busy[p]                = (pend_r[rd_addr[p*AW +: AW]] != '0);
        end
      end else begin
        rd_data[p*WIDTH +: WIDTH] = '0;
        rd_busy[p]                = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pinky_scoreboard_regfile.sv
// Directed bench for pinky_scoreboard_regfile: default build plus a ZERO_R0=1 build
// sharing the same stimulus.
module tb_pinky_scoreboard_regfile;

  logic        clk;
  logic        reset;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic        iss_wen;
  logic [3:0]  iss_dest;
  logic        iss_ready;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic [15:0] wb_data;
  logic        err;
  logic [31:0] z_rd_data;
  logic [1:0]  z_rd_busy;
  logic        z_iss_ready;
  logic        z_err;

  int vectors = 0;
  int miscompares = 0;

  pinky_scoreboard_regfile dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .err(err)
  );

  pinky_scoreboard_regfile #(.ZERO_R0(1)) dut_z (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dest(iss_dest), .iss_ready(z_iss_ready),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .err(z_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] d, input logic [15:0] v);
    wb_valid = 1'b1;
    wb_dest  = d;
    wb_data  = v;
  endtask

  initial begin
    reset = 1'b0; rd_addr = 8'h00; iss_valid = 1'b0; iss_wen = 1'b1; iss_dest = 4'h0;
    wb_valid = 1'b0; wb_dest = 4'h0; wb_data = 16'h0000;
    #3;
    chk("rst_err", {31'd0, err}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    #1;

    // 1: everything reads zero after reset
    for (int r = 0; r < 16; r++) begin
      rd(4'(r), 4'(r));
      #1;
      chk("t1_data", rd_data, 32'h0000_0000);
      chk("t1_busy", {30'd0, rd_busy}, 32'd0);
    end
    chk("t1_ready", {31'd0, iss_ready}, 32'd1);
    chk("t1_err", {31'd0, err}, 32'd0);
    tick();

    // 2: issue r3, then bypass write-back
    iss_valid = 1'b1; iss_dest = 4'd3; rd(4'd3, 4'd3);
    #1;
    chk("t2_busy_same_cycle", {30'd0, rd_busy}, 32'd0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("t2_busy_pending", {30'd0, rd_busy}, 32'd3);
    chk("t2_data_pending", rd_data, 32'h0000_0000);
    wb(4'd3, 16'hBEEF);
    #1;
    chk("t2_bypass_data", rd_data, 32'hBEEF_BEEF);
    chk("t2_bypass_busy", {30'd0, rd_busy}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("t2_after_data", rd_data, 32'hBEEF_BEEF);
    chk("t2_after_busy", {30'd0, rd_busy}, 32'd0);
    chk("t2_err", {31'd0, err}, 32'd0);

    // 3: saturate r5 at three pending writes
    iss_valid = 1'b1; iss_dest = 4'd5; rd(4'd5, 4'd5);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_ready_fill", {31'd0, iss_ready}, 32'd1);
      tick();
    end
    #1;
    chk("t3_ready_full", {31'd0, iss_ready}, 32'd0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("t3_busy_full", {30'd0, rd_busy}, 32'd3);
    wb(4'd5, 16'h1234);
    #1;
    chk("t3_old_data", rd_data, 32'h0000_0000);
    chk("t3_busy_wb", {30'd0, rd_busy}, 32'd3);
    chk("t3_ready_wb", {31'd0, iss_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("t3_ready_after", {31'd0, iss_ready}, 32'd1);
    chk("t3_data_after", rd_data, 32'h1234_1234);
    chk("t3_busy_after", {30'd0, rd_busy}, 32'd3);
    wb(4'd5, 16'h2222);
    #1;
    chk("t3_pend2_data", rd_data, 32'h1234_1234);
    tick();
    wb(4'd5, 16'h3333);
    #1;
    chk("t3_last_bypass", rd_data, 32'h3333_3333);
    chk("t3_last_busy", {30'd0, rd_busy}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("t3_drained_busy", {30'd0, rd_busy}, 32'd0);
    chk("t3_err", {31'd0, err}, 32'd0);

    // 4: simultaneous issue and write-back to r7 keeps pend at 1
    iss_valid = 1'b1; iss_dest = 4'd7; rd(4'd7, 4'd7);
    tick();
    wb(4'd7, 16'h0012);
    #1;
    chk("t4_bypass", rd_data, 32'h0012_0012);
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("t4_data", rd_data, 32'h0012_0012);
    chk("t4_busy", {30'd0, rd_busy}, 32'd3);
    wb(4'd7, 16'h0013);
    #1;
    chk("t4_drain_bypass", rd_data, 32'h0013_0013);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("t4_drain_busy", {30'd0, rd_busy}, 32'd0);
    chk("t4_err", {31'd0, err}, 32'd0);

    // 5: underflow on r9 sets sticky err
    rd(4'd9, 4'd9);
    wb(4'd9, 16'h0001);
    #1;
    chk("t5_no_bypass", rd_data, 32'h0000_0000);
    chk("t5_err_before", {31'd0, err}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("t5_data", rd_data, 32'h0001_0001);
    chk("t5_err_set", {31'd0, err}, 32'd1);
    iss_valid = 1'b1; iss_dest = 4'd1;
    tick();
    iss_valid = 1'b0;
    wb(4'd1, 16'h0005);
    tick();
    wb_valid = 1'b0;
    rd(4'd1, 4'd9);
    #1;
    chk("t5_traffic_data", rd_data, 32'h0001_0005);
    chk("t5_traffic_busy", {30'd0, rd_busy}, 32'd0);
    chk("t5_err_held", {31'd0, err}, 32'd1);

    // 6: asynchronous reset mid-cycle, then ZERO_R0 behaviour
    iss_valid = 1'b1; iss_dest = 4'd2; rd(4'd2, 4'd3);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("t6_busy_pre", {30'd0, rd_busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_data", rd_data, 32'h0000_0000);
    chk("t6_rst_busy", {30'd0, rd_busy}, 32'd0);
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    chk("t6_rst_ready", {31'd0, iss_ready}, 32'd1);
    tick(); tick();
    reset = 1'b1;
    rd(4'd0, 4'd0);
    wb(4'd0, 16'hFFFF);
    #1;
    chk("t6_z_wb_data", z_rd_data, 32'h0000_0000);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("t6_data_r0", rd_data, 32'hFFFF_FFFF);
    chk("t6_err_after_release", {31'd0, err}, 32'd1);
    chk("t6_z_data", z_rd_data, 32'h0000_0000);
    chk("t6_z_err", {31'd0, z_err}, 32'd0);
    iss_valid = 1'b1; iss_dest = 4'd0;
    tick();
    iss_valid = 1'b0;
    #1;
    chk("t6_z_busy_r0", {30'd0, z_rd_busy}, 32'd0);
    chk("t6_busy_r0", {30'd0, rd_busy}, 32'd3);
    chk("t6_z_ready", {31'd0, z_iss_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
